// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex-display scanner feeding dec_7seg, with frame-synchronous updates and dead time.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LEAD_ZERO_BLANK_EN.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned CLK_DIV   = 1000,
    parameter int unsigned BLANK_CYC = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*DIGITS-1:0]   i_dat,
    input  logic                  i_load,
    output logic [3:0]            o_nib,
    output logic [DIGITS-1:0]     o_an,
    output logic                  o_blank,
    output logic                  o_frame
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned IW = $clog2(DIGITS);
    localparam int unsigned DW = 4 * DIGITS;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     pend_q, pend_d;
    logic [DW-1:0]     disp_q, disp_d;
    logic              pend_vld_q, pend_vld_d;

    logic [DIGITS-1:0] an_q, an_d;
    logic [3:0]        nib_q, nib_d;
    logic              blank_q, blank_d;
    logic              frame_q, frame_d;

    logic              slot_end;
    logic              wrap;
    logic              dead;
    logic              digit_off;
    logic [DIGITS-1:0] supp;

    generate
        if (BLANK_CYC == 0) begin : g_no_dead
            assign dead = 1'b0;
        end else begin : g_dead
            assign dead = (cnt_q < CW'(BLANK_CYC));
        end
    endgenerate

`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
    // supp[k] is set when every nibble from the top down to k is zero; digit 0 always shows.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        supp     = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (disp_q[4*k +: 4] == 4'h0);
            supp[k]  = zero_run;
        end
    end
`else
    assign supp = '0;
`endif

    always_comb begin
        slot_end   = (cnt_q == CW'(CLK_DIV - 1));
        wrap       = slot_end && (idx_q == IW'(DIGITS - 1));

        cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
        idx_d      = idx_q;
        if (slot_end) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end

        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;
        if (wrap) begin
            // A load landing on the boundary bypasses the pending register.
            if (i_load) begin
                disp_d = i_dat;
            end else if (pend_vld_q) begin
                disp_d = pend_q;
            end
            pend_vld_d = 1'b0;
        end else if (i_load) begin
            pend_d     = i_dat;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        nib_d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib_d = disp_q[4*k +: 4];
            end
        end
        digit_off = dead || supp[idx_q];
        an_d      = digit_off ? '1 : ~(DIGITS'(1) << idx_q);
        blank_d   = digit_off;
        frame_d   = wrap;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_q     <= '0;
            disp_q     <= '0;
            pend_vld_q <= 1'b0;
            an_q       <= '1;
            nib_q      <= '0;
            blank_q    <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            disp_q     <= disp_d;
            pend_vld_q <= pend_vld_d;
            an_q       <= an_d;
            nib_q      <= nib_d;
            blank_q    <= blank_d;
            frame_q    <= frame_d;
        end
    end

    assign o_an    = an_q;
    assign o_nib   = nib_q;
    assign o_blank = blank_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, CLK_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] dat;
    logic        load;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic        blank;
    logic        frame;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    seg_scan_ctrl #(
        .DIGITS    (4),
        .CLK_DIV   (8),
        .BLANK_CYC (2)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_dat   (dat),
        .i_load  (load),
        .o_nib   (nib),
        .o_an    (an),
        .o_blank (blank),
        .o_frame (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    // One clock edge with optional load, then check outputs against the value shown this edge.
    task automatic step(input logic ld, input logic [15:0] d, input logic [15:0] shown);
        int c;
        int di;
        logic [3:0] one;
        logic [3:0] exp_an;
        logic       off;
        logic       sup;
        load = ld;
        dat  = d;
        @(posedge clk);
        #1;
        load = 1'b0;
        k++;
        c   = (k - 1) % 8;
        di  = ((k - 1) / 8) % 4;
        one = 4'b0001;
`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
        sup = (di >= 1) && ((shown >> (4 * di)) == 16'h0);
`else
        sup = 1'b0;
`endif
        off    = (c < 2) || sup;
        exp_an = off ? 4'hF : ~(one << di);
        check("an", 32'(an), 32'(exp_an));
        check("blank", 32'(blank), 32'(off));
        check("nib", 32'(nib), 32'(shown[4*di +: 4]));
        check("frame", 32'(frame), 32'((k % 32) == 0));
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        dat   = 16'h0;
        #12;
        check("rst_an", 32'(an), 32'hF);
        check("rst_blank", 32'(blank), 32'h1);
        check("rst_nib", 32'(nib), 32'h0);
        check("rst_frame", 32'(frame), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan of the reset value.
        while (k < 39) step(1'b0, 16'h0, 16'h0);
        // Mid-frame load only takes effect after the next boundary.
        step(1'b1, 16'h1A3F, 16'h0);
        while (k < 64) step(1'b0, 16'h0, 16'h0);
        while (k < 96) step(1'b0, 16'h0, 16'h1A3F);
        // Two loads in one frame: the later one wins.
        while (k < 100) step(1'b0, 16'h0, 16'h1A3F);
        step(1'b1, 16'h1111, 16'h1A3F);
        while (k < 110) step(1'b0, 16'h0, 16'h1A3F);
        step(1'b1, 16'h2222, 16'h1A3F);
        while (k < 128) step(1'b0, 16'h0, 16'h1A3F);
        // Pending 3333 is overridden by a load on the boundary edge itself.
        while (k < 150) step(1'b0, 16'h0, 16'h2222);
        step(1'b1, 16'h3333, 16'h2222);
        while (k < 159) step(1'b0, 16'h0, 16'h2222);
        step(1'b1, 16'hBEEF, 16'h2222);
        while (k < 227) step(1'b0, 16'h0, 16'hBEEF);

        // Asynchronous reset between edges while digit 0 (F) is lit.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_an", 32'(an), 32'hF);
        check("arst_blank", 32'(blank), 32'h1);
        check("arst_nib", 32'(nib), 32'h0);
        check("arst_frame", 32'(frame), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (k < 63) step(1'b0, 16'h0, 16'h0);
        // Leading-zero patterns (plain display when suppression is not built in).
        step(1'b1, 16'h0050, 16'h0);
        while (k < 95) step(1'b0, 16'h0, 16'h0050);
        step(1'b1, 16'h0000, 16'h0050);
        while (k < 128) step(1'b0, 16'h0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
